// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control pipeline: control bundle layout,
// ALUOp codes, operand forward selects and the bubble value.
package ctrl_pkg;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [1:0] ALU_OP_MEM    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_R      = 2'b10;
  localparam logic [1:0] ALU_OP_I      = 2'b11;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // x0 is hardwired to zero, so a zero destination never creates a dependency.
  function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection and operand-forward selection.
// CTRL_PIPE_FWD_EN enables EX/MEM and MEM/WB forwarding; without it, RAW
// dependencies on EX and MEM writers stall instead.
module hazard_unit
  import ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_rd,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_rd,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_rd,
  output logic       stall,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic ex_hit;
  logic mem_hit;
  logic load_use;

  always_comb begin
    ex_hit   = rd_hit(ex_rd, id_rs1) || rd_hit(ex_rd, id_rs2);
    mem_hit  = rd_hit(mem_rd, id_rs1) || rd_hit(mem_rd, id_rs2);
    load_use = ex_mem_read && ex_hit;
  end

`ifdef CTRL_PIPE_FWD_EN
  logic unused_mem_hit;
  assign unused_mem_hit = mem_hit ^ ex_reg_write;

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  always_comb begin
    stall = load_use;
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (mem_reg_write && rd_hit(mem_rd, ex_rs1))     fwd_a = FWD_EXMEM;
    else if (wb_reg_write && rd_hit(wb_rd, ex_rs1))  fwd_a = FWD_MEMWB;
    if (mem_reg_write && rd_hit(mem_rd, ex_rs2))     fwd_b = FWD_EXMEM;
    else if (wb_reg_write && rd_hit(wb_rd, ex_rs2))  fwd_b = FWD_MEMWB;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_rs1, ex_rs2, wb_reg_write, wb_rd};

  // WB needs no check: the regfile writes before it is read.
  always_comb begin
    stall = load_use || (ex_reg_write && ex_hit) || (mem_reg_write && mem_hit);
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
  end
`endif

endmodule

// File: rtl/ctrl_pipeline.sv
// ID->EX->MEM->WB control/destination pipeline with stall, flush and a
// saturating stall counter. Forwarding is selected by CTRL_PIPE_FWD_EN.
module ctrl_pipeline
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  id_ctrl,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        ex_branch_taken,
  output logic [7:0]  ex_ctrl,
  output logic [7:0]  mem_ctrl,
  output logic [7:0]  wb_ctrl,
  output logic [4:0]  ex_rd,
  output logic [4:0]  mem_rd,
  output logic [4:0]  wb_rd,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        if_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_count
);

  ctrl_t       ex_ctrl_q, ex_ctrl_d;
  ctrl_t       mem_ctrl_q, mem_ctrl_d;
  ctrl_t       wb_ctrl_q, wb_ctrl_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic [4:0]  ex_rs1_q, ex_rs1_d;
  logic [4:0]  ex_rs2_q, ex_rs2_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic       stall_raw;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;
  logic       flush;
  logic       stall;
  logic       bubble;

  hazard_unit u_hazard (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_mem_read   (ex_ctrl_q.mem_read),
    .ex_reg_write  (ex_ctrl_q.reg_write),
    .ex_rd         (ex_rd_q),
    .ex_rs1        (ex_rs1_q),
    .ex_rs2        (ex_rs2_q),
    .mem_reg_write (mem_ctrl_q.reg_write),
    .mem_rd        (mem_rd_q),
    .wb_reg_write  (wb_ctrl_q.reg_write),
    .wb_rd         (wb_rd_q),
    .stall         (stall_raw),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  // A taken branch squashes the stalled instruction, so flush overrides stall.
  always_comb begin
    flush  = ex_branch_taken && !reset;
    stall  = stall_raw && !ex_branch_taken && !reset;
    bubble = flush || stall;
  end

  always_comb begin
    ex_ctrl_d     = bubble ? CTRL_BUBBLE : ctrl_t'(id_ctrl);
    ex_rd_d       = bubble ? 5'd0 : id_rd;
    ex_rs1_d      = bubble ? 5'd0 : id_rs1;
    ex_rs2_d      = bubble ? 5'd0 : id_rs2;
    mem_ctrl_d    = ex_ctrl_q;
    mem_rd_d      = ex_rd_q;
    wb_ctrl_d     = mem_ctrl_q;
    wb_rd_d       = mem_rd_q;
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ctrl_q     <= CTRL_BUBBLE;
      mem_ctrl_q    <= CTRL_BUBBLE;
      wb_ctrl_q     <= CTRL_BUBBLE;
      ex_rd_q       <= 5'd0;
      ex_rs1_q      <= 5'd0;
      ex_rs2_q      <= 5'd0;
      mem_rd_q      <= 5'd0;
      wb_rd_q       <= 5'd0;
      stall_count_q <= 16'd0;
    end else begin
      ex_ctrl_q     <= ex_ctrl_d;
      mem_ctrl_q    <= mem_ctrl_d;
      wb_ctrl_q     <= wb_ctrl_d;
      ex_rd_q       <= ex_rd_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      mem_rd_q      <= mem_rd_d;
      wb_rd_q       <= wb_rd_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_ctrl     = ex_ctrl_q;
  assign mem_ctrl    = mem_ctrl_q;
  assign wb_ctrl     = wb_ctrl_q;
  assign ex_rd       = ex_rd_q;
  assign mem_rd      = mem_rd_q;
  assign wb_rd       = wb_rd_q;
  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign if_flush    = flush;
  assign fwd_a       = reset ? FWD_RF : fwd_a_raw;
  assign fwd_b       = reset ? FWD_RF : fwd_b_raw;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: directed cases, random traffic and
// stall-counter saturation against a stage-array reference model.
module tb_ctrl_pipeline;

  localparam logic [7:0] C_NOP = 8'h00;
  localparam logic [7:0] C_LW  = 8'b0110_1100; // mem_read, mem_to_reg, alu_src, reg_write
  localparam logic [7:0] C_SW  = 8'b0001_1000; // mem_write, alu_src
  localparam logic [7:0] C_ADD = 8'b0000_0110; // reg_write, R-type
  localparam logic [7:0] C_BEQ = 8'b1000_0001; // branch

  logic        clk;
  logic        reset;
  logic [7:0]  id_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_branch_taken;
  logic [7:0]  ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        pc_write, ifid_write, if_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 0;

  ctrl_pipeline dut (
    .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .ex_branch_taken(ex_branch_taken), .ex_ctrl(ex_ctrl),
    .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .wb_rd(wb_rd), .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: index 0 = EX, 1 = MEM, 2 = WB
  logic [7:0] m_ctrl [3];
  logic [4:0] m_rd   [3];
  logic [4:0] m_rs1_ex, m_rs2_ex;
  int         m_sc;
  int         m_sc_raw;

  function automatic bit dep(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 0) && (rd == rs);
  endfunction

  function automatic bit m_stall_cond();
    bit ex_dep, mem_dep, s;
    ex_dep  = dep(m_rd[0], id_rs1) || dep(m_rd[0], id_rs2);
    mem_dep = dep(m_rd[1], id_rs1) || dep(m_rd[1], id_rs2);
    s = m_ctrl[0][6] && ex_dep;
`ifndef CTRL_PIPE_FWD_EN
    s = s || (m_ctrl[0][2] && ex_dep) || (m_ctrl[1][2] && mem_dep);
`endif
    return s;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
`ifdef CTRL_PIPE_FWD_EN
    if (m_ctrl[1][2] && dep(m_rd[1], rs)) return 2'b10;
    if (m_ctrl[2][2] && dep(m_rd[2], rs)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin m_ctrl[i] = '0; m_rd[i] = '0; end
      m_rs1_ex = '0; m_rs2_ex = '0; m_sc = 0; m_sc_raw = 0;
    end else begin
      bit st;
      st = m_stall_cond() && !ex_branch_taken;
      m_ctrl[2] = m_ctrl[1]; m_rd[2] = m_rd[1];
      m_ctrl[1] = m_ctrl[0]; m_rd[1] = m_rd[0];
      if (st || ex_branch_taken) begin
        m_ctrl[0] = '0; m_rd[0] = '0; m_rs1_ex = '0; m_rs2_ex = '0;
      end else begin
        m_ctrl[0] = id_ctrl; m_rd[0] = id_rd; m_rs1_ex = id_rs1; m_rs2_ex = id_rs2;
      end
      if (st) begin
        m_sc_raw++;
        if (m_sc < 16'hFFFF) m_sc++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      if (err_cnt <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare process: one check set per cycle
  always @(negedge clk) begin
    if (chk_en) begin
      bit s;
      s = !reset && !ex_branch_taken && m_stall_cond();
      chk("pc_write",    {31'd0, pc_write},   {31'd0, !s});
      chk("ifid_write",  {31'd0, ifid_write}, {31'd0, !s});
      chk("if_flush",    {31'd0, if_flush},   {31'd0, ex_branch_taken && !reset});
      chk("fwd_a",       {30'd0, fwd_a},      {30'd0, reset ? 2'b00 : m_fwd(m_rs1_ex)});
      chk("fwd_b",       {30'd0, fwd_b},      {30'd0, reset ? 2'b00 : m_fwd(m_rs2_ex)});
      chk("ex_ctrl",     {24'd0, ex_ctrl},    {24'd0, m_ctrl[0]});
      chk("mem_ctrl",    {24'd0, mem_ctrl},   {24'd0, m_ctrl[1]});
      chk("wb_ctrl",     {24'd0, wb_ctrl},    {24'd0, m_ctrl[2]});
      chk("ex_rd",       {27'd0, ex_rd},      {27'd0, m_rd[0]});
      chk("mem_rd",      {27'd0, mem_rd},     {27'd0, m_rd[1]});
      chk("wb_rd",       {27'd0, wb_rd},      {27'd0, m_rd[2]});
      chk("stall_count", {16'd0, stall_count}, m_sc[31:0]);
    end
  end

  // driver tasks
  task automatic drive(input logic [7:0] c, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic br);
    id_ctrl = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; ex_branch_taken = br;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      drive(C_NOP, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(C_NOP, 0, 0, 0, 0);
    repeat (2) step();
    drive(C_LW, 5, 5, 5, 1);
    chk("rst_pc_write",   {31'd0, pc_write},   32'd1);
    chk("rst_ifid_write", {31'd0, ifid_write}, 32'd1);
    chk("rst_if_flush",   {31'd0, if_flush},   32'd0);
    chk("rst_fwd_a",      {30'd0, fwd_a},      32'd0);
    chk("rst_stall_cnt",  {16'd0, stall_count}, 32'd0);
    chk("rst_ex_ctrl",    {24'd0, ex_ctrl},    32'd0);
    drive(C_NOP, 0, 0, 0, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    step();

    // load-use: lw x5 in EX, ID reads x5
    drive(C_LW, 0, 0, 5, 0); step();
    drive(C_ADD, 5, 0, 6, 0);
    chk("lu_pc_write",   {31'd0, pc_write},   32'd0);
    chk("lu_ifid_write", {31'd0, ifid_write}, 32'd0);
    step();
    chk("lu_ex_bubble",  {24'd0, ex_ctrl},     32'd0);
    chk("lu_stall_cnt",  {16'd0, stall_count}, 32'd1);
    drain();

    // branch flush with simultaneous load-use
    drive(C_LW, 0, 0, 5, 0); step();
    drive(C_ADD, 5, 0, 6, 1);
    chk("br_if_flush", {31'd0, if_flush}, 32'd1);
    chk("br_pc_write", {31'd0, pc_write}, 32'd1);
    step();
    chk("br_ex_bubble", {24'd0, ex_ctrl},     32'd0);
    chk("br_stall_cnt", {16'd0, stall_count}, 32'd1);
    drain();

    // x0 writer never hazards
    drive(C_ADD, 0, 0, 0, 0); step();
    drive(C_ADD, 0, 0, 7, 0);
    chk("x0_pc_write", {31'd0, pc_write}, 32'd1);
    step();
    chk("x0_fwd_a", {30'd0, fwd_a}, 32'd0);
    drain();

`ifdef CTRL_PIPE_FWD_EN
    drive(C_ADD, 0, 0, 3, 0); step();
    drive(C_ADD, 0, 0, 3, 0); step();
    drive(C_ADD, 3, 0, 9, 0); step();
    chk("fwd_exmem_wins", {30'd0, fwd_a}, 32'd2);
    drive(C_ADD, 0, 0, 3, 0); step();
    drive(C_NOP, 0, 0, 0, 0); step();
    drive(C_ADD, 3, 0, 9, 0); step();
    chk("fwd_wb_only", {30'd0, fwd_a}, 32'd1);
    drain();
`else
    drive(C_ADD, 0, 0, 3, 0); step();
    drive(C_ADD, 0, 3, 8, 0);
    chk("raw_ex_stall", {31'd0, pc_write}, 32'd0);
    step();
    chk("raw_stall_cnt", {16'd0, stall_count}, 32'd2);
    step();
    chk("raw_wb_no_stall", {31'd0, pc_write}, 32'd1);
    chk("raw_stall_cnt2", {16'd0, stall_count}, 32'd3);
    step();
    drain();
`endif

    // reset arriving mid-stall, between clock edges
    drive(C_LW, 0, 0, 5, 0); step();
    drive(C_ADD, 5, 0, 6, 0);
    chk("mid_stalling", {31'd0, pc_write}, 32'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_pc_write",   {31'd0, pc_write},    32'd1);
    chk("mid_ifid_write", {31'd0, ifid_write},  32'd1);
    chk("mid_ex_ctrl",    {24'd0, ex_ctrl},     32'd0);
    chk("mid_mem_ctrl",   {24'd0, mem_ctrl},    32'd0);
    chk("mid_stall_cnt",  {16'd0, stall_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drain();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [7:0] c;
      case ($urandom_range(0, 5))
        0: c = C_LW;
        1: c = C_SW;
        2: c = C_ADD;
        3: c = C_BEQ;
        4: c = C_NOP;
        default: c = 8'($urandom_range(0, 255));
      endcase
      drive(c, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
      step();
    end

    // saturation: back-to-back dependent loads until 65540 stalls
    reset = 1'b1; #1; reset = 1'b0;
    drive(C_LW, 5, 5, 5, 0);
    for (int n = 0; n < 140000 && m_sc_raw < 65540; n++) step();
    if (m_sc_raw < 65540) chk("sat_budget", m_sc_raw[31:0], 32'd65540);
    chk("sat_stall_cnt", {16'd0, stall_count}, 32'h0000FFFF);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
